// File: rtl/rails_checker_p.sv
// rtl/rails_checker_p.sv - stack-permutation (rails) checker with length/duplicate/range detection
// Streams N then N cars; reports legality, illegal length, and first offending car index.
module rails_checker_p #(
  parameter int MAX_N = 15,
  parameter int DW    = $clog2(MAX_N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_result,
  output logic          out_err,
  output logic [DW-1:0] out_fail_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [DW:0] MAX_W = (DW + 1)'(MAX_N);

  state_t        state, state_nxt;
  logic [DW-1:0] n;
  logic [DW-1:0] pos;
  logic [DW-1:0] top;
  logic [DW:0]   next_in;   // one bit wider: reaches N+1 after car N is taken
  logic [MAX_N:0] used;
  logic          fail;

  logic xfer, len_bad, in_range, above, legal, last;

  assign xfer     = in_valid && in_ready;
  assign len_bad  = (in_data == '0) || ({1'b0, in_data} > MAX_W);
  assign in_range = (in_data != '0) && (in_data <= n);
  assign above    = {1'b0, in_data} >= next_in;
  assign legal    = in_range && !used[in_data] && (above || (in_data == top));
  assign last     = (pos + 1'b1) == n;

  // Stack top: the highest already-pushed car not yet popped.
  always_comb begin
    top = '0;
    for (int i = 1; i <= MAX_N; i++) begin
      if (((DW + 1)'(i) < next_in) && !used[i]) top = DW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = len_bad ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (xfer && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n            <= '0;
      pos          <= '0;
      next_in      <= '0;
      used         <= '0;
      fail         <= 1'b0;
      out_result   <= 1'b0;
      out_err      <= 1'b0;
      out_fail_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            n            <= in_data;
            pos          <= '0;
            next_in      <= (DW + 1)'(1);
            used         <= '0;
            fail         <= 1'b0;
            out_result   <= 1'b0;
            out_err      <= len_bad;
            out_fail_idx <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            pos <= pos + 1'b1;
            if (above) next_in <= {1'b0, in_data} + 1'b1;
            if (in_range) used[in_data] <= 1'b1;
            if (!legal && !fail) begin
              fail         <= 1'b1;
              out_fail_idx <= pos + 1'b1;
            end
            if (last) begin
              out_result <= !fail && legal;
              out_err    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rails_checker_p.md
Name: rails_checker_p

Overview:
- Parametrised successor of the single-channel rails (stack-permutation) checker.
- Accepts a train length N, then N car numbers over a valid/ready stream. Reports whether the sequence can be produced by pushing cars 1..N through a single stack siding.
- Adds: configurable maximum train length, full input/output handshakes, an explicit FSM, detection of illegal length, duplicate and out-of-range cars, and the index of the first offending car.
- Sits between the stimulus stream source and the scoreboard/result collector.

Parameters:
- MAX_N, 15: maximum train length; legal N is 1..MAX_N.
- DW, $clog2(MAX_N+1): width of length and car fields; the instantiator must not override it below this value.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  DW  first beat of a train = N; next N beats = car numbers.
- out_valid  output  1  verdict valid; held until accepted.
- out_ready  input  1  consumer accepts verdict.
- out_result  output  1  1 = sequence is a legal stack permutation.
- out_err  output  1  1 = illegal length N (0 or >MAX_N).
- out_fail_idx  output  DW  1-based position of the first offending car; 0 if none.

Behaviour:
- Reset and handshake:
  - Reset is synchronous, active-high. It has priority over everything, including mid-train; the partial train is discarded.
  - After reset: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_err=0, out_fail_idx=0, all internal state cleared.
  - A beat transfers when in_valid && in_ready. The verdict transfers when out_valid && out_ready.
- FSM, IDLE (in_ready=1):
  - On transfer, latch N=in_data.
  - If N==0 or N>MAX_N: go to DONE with result=0, err=1, fail_idx=0.
  - Otherwise: go to RUN with pos=0, next_in=1, used bitmap cleared, fail=0.
- FSM, RUN (in_ready=1): each transferred car c increments pos (1-based). The car is evaluated against the stack model:
  - Stack contents = cars < next_in whose used bit is clear. top = highest such car, found by a one-cycle priority encode; top=0 if empty.
  - Legal if 1<=c<=N and !used[c] and (c>=next_in or c==top).
  - If c>=next_in: set next_in=c+1 (cars next_in..c-1 are implicitly pushed).
  - Set used[c]=1 for any in-range c.
  - On the first illegal car: fail=1 and fail_idx=pos. Later cars are still consumed but do not change fail_idx.
  - After the N-th car is transferred: go to DONE. result=!fail, err=0.
- FSM, DONE (in_ready=0, out_valid=1): outputs are stable. On an out_valid&&out_ready cycle, go to IDLE and drop out_valid on the next cycle.
- Latency and throughput:
  - The verdict is visible on the cycle after the last car, or after the illegal length, is accepted.
  - Best throughput: one beat per cycle. The block spends one DONE cycle per train when out_ready is held high.
- Arithmetic:
  - Car and length compares are unsigned, DW bits.
  - The used bitmap is MAX_N+1 bits, with index 0 unused.
  - A car value of 0 or >N is out-of-range and illegal. It does not index the bitmap.
- Boundary cases:
  - N=1 with car 1: legal.
  - N=MAX_N: the full bitmap is exercised.
  - in_valid gaps mid-train: the state is held.
  - in_valid asserted while in DONE: not accepted, because in_ready=0.
  - Reset together with the final car: reset wins and no verdict is produced.

Test Plan:
- N=5, cars 3,4,2,1,5 without gaps -> one cycle after car 5: out_valid=1, result=1, err=0, fail_idx=0.
- N=5, cars 5,4,1,2,3 -> result=0, fail_idx=3 (car 1 is below the stack top 3). out_valid is asserted only after the 5th car.
- N=0, then separately N=MAX_N+1 -> immediate DONE with err=1, result=0. in_ready=0 until the verdict is accepted.
- N=4, cars 2,2,1,3 -> result=0, fail_idx=2 (duplicate). N=3, cars 1,0,2 -> result=0, fail_idx=2 (out-of-range).
- N=MAX_N, descending MAX_N..1 with random in_valid gaps and out_ready held low 5 cycles -> result=1. Outputs are stable for all 5 stalled cycles, then the block returns to IDLE.
- Reset asserted after 2 cars of an N=4 train, then N=2, cars 2,1 -> only one verdict appears: result=1.
